key_debounce_events: RTL
========================

// Module: key_debounce_events
// PURPOSE
//  Upstream conditioning stage for the macro-keypad switches (swA..swF, swU).
//  - 2-FF synchronises each raw key, debounces it against a shared tick, and outputs clean per-key levels.
//  - The levels feed the SoC button PIO input.
//  - Also serialises press/release events into a valid/ack event register, so the CPU or a UART reporter never misses a key edge.
// PARAMETERS
//  NUM_KEYS            7      number of keys, 1..16
//  ACTIVE_LOW          1      1: raw input 0 = pressed (pull-ups); 0: raw 1 = pressed
//  TICK_DIV            12090  clk cycles per tick (1 ms at 12.09 MHz); >=2
//  DEBOUNCE_TICKS      5      consecutive ticks of stable new value before level changes; >=1
//  REPEAT_DELAY_TICKS  500    hold time before first auto-repeat (KEY_REPEAT_EN only)
//  REPEAT_RATE_TICKS   100    interval between auto-repeats (KEY_REPEAT_EN only)
// PORTS
//  clk_i          in   1         system clock
//  rst_i          in   1         synchronous reset, active-high
//  key_raw_i      in   NUM_KEYS  raw asynchronous switch pins
//  key_level_o    out  NUM_KEYS  debounced level, 1 = pressed (to button PIO)
//  key_press_o    out  NUM_KEYS  1-clk pulse per key on debounced press
//  key_release_o  out  NUM_KEYS  1-clk pulse per key on debounced release
//  evt_valid_o    out  1         event register holds an unconsumed event
//  evt_code_o     out  6         {repeat, press(1)/release(0), key_idx[3:0]}
//  evt_ack_i      in   1         consumer takes event; honoured only while evt_valid_o=1
//  evt_overflow_o out  1         sticky: an event was lost; cleared only by rst_i
// BEHAVIOUR
//  Reset (rst_i=1 at a clk edge) clears all state. Every output reads 0 the next cycle; this includes a reset mid-debounce or mid-event.
//  The synchroniser reset value equals the "released" raw level. No phantom press leaves reset.
//  Sync: 2 flops per key; sample s[i] = pressed-polarity-corrected 2nd flop.
//  Tick: free-running counter 0..TICK_DIV-1; tick=1 for one clk when it wraps.
//  Debounce, per key:
//    - s[i]==level[i]: cnt[i]<=0.
//    - s[i]!=level[i] on a tick: cnt[i]++.
//    - When cnt[i]==DEBOUNCE_TICKS-1 and a tick occurs: level[i] toggles and cnt[i]<=0.
//    - A glitch shorter than DEBOUNCE_TICKS ticks never changes the level; any return to the old value restarts the count.
//  key_press_o[i]/key_release_o[i] are registered with key_level_o and are high exactly in the first cycle of the new level.
//  Pending flags: press_pend[i] is set on a press pulse and rel_pend[i] on a release pulse.
//    - Each flag is cleared when its event loads into the event register.
//    - If a pulse arrives for a flag that is already set, evt_overflow_o<=1 and the flag stays set.
//    - If set and clear hit the same cycle, set wins and overflow is not flagged.
//  Serialiser, 1-entry register with valid/ack:
//    - Loads when evt_valid_o=0, or when evt_ack_i=1 in the same cycle (back-to-back, 1 event/clk max).
//    - Priority: lowest-index press_pend first, then lowest-index rel_pend. A key pressed and released before service therefore reports press before release.
//    - A pulse reaches evt_valid_o 2 clks after key_press_o (flag, then load).
//    - evt_ack_i while evt_valid_o=0 is ignored.
//    - evt_code_o holds stable while evt_valid_o=1 and no ack.
//  Widths: cnt is clog2(DEBOUNCE_TICKS+1) bits; the tick counter is clog2(TICK_DIV) bits. Unused idx bits read 0.
// CONFIGURATION
//  KEY_REPEAT_EN defined:
//    - Per-key hold counter in ticks, started on a debounced press.
//    - After REPEAT_DELAY_TICKS, and then every REPEAT_RATE_TICKS while held, a repeat event is raised: press_pend set plus rep_pend set.
//    - Emitted code is {1,1,idx}. Overflow rules are the same as for presses.
//    - Release stops and clears the hold counter.
//  KEY_REPEAT_EN undefined:
//    - No hold counters or repeat logic synthesised.
//    - evt_code_o[5] is tied 0.
//    - REPEAT_* parameters are unused.
// TESTING (bench: TICK_DIV=4, DEBOUNCE_TICKS=3, ACTIVE_LOW=1, NUM_KEYS=7)
//  1 Reset, key_raw_i=7'h7F for 50 clks -> all outputs 0; no events.
//  2 key_raw_i[2]=0 held -> key_level_o=7'h04 within 2+3*4+1 clks.
//    key_press_o[2] pulses 1 clk; evt_code_o=6'b01_0010 valid 2 clks later.
//  3 key_raw_i[0] low for 2 ticks, then high, repeated 5x -> key_level_o stays 0; no pulses; no events.
//  4 Keys 5 and 1 pressed same cycle, evt_ack_i held 1 -> events 6'h11 then 6'h15 on consecutive clks; evt_valid_o then drops.
//  5 evt_ack_i=0, key 3 press, release, press -> evt_overflow_o=1.
//    Ack sequence yields 6'h13 then 6'h03 only.
//  6 rst_i pulsed mid-debounce of key 4 with raw still low -> outputs 0 next clk; a fresh full debounce is needed before level rises.
//    With KEY_REPEAT_EN, REPEAT_DELAY=6, RATE=2, hold key 6 -> 6'h16, then 6'h36 after 6 ticks, then every 2 ticks.

Source files
------------

// File: rtl/key_debounce_events.sv
// Keypad conditioner: 2-FF sync, tick-based debounce, press/release pulses and a 1-entry valid/ack event register.
// Optional auto-repeat is built when KEY_REPEAT_EN is defined.
module key_debounce_events #(
  parameter int NUM_KEYS           = 7,
  parameter int ACTIVE_LOW         = 1,
  parameter int TICK_DIV           = 12090,
  parameter int DEBOUNCE_TICKS     = 5,
  parameter int REPEAT_DELAY_TICKS = 500,
  parameter int REPEAT_RATE_TICKS  = 100
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_KEYS-1:0] key_raw_i,
  output logic [NUM_KEYS-1:0] key_level_o,
  output logic [NUM_KEYS-1:0] key_press_o,
  output logic [NUM_KEYS-1:0] key_release_o,
  output logic                evt_valid_o,
  output logic [5:0]          evt_code_o,
  input  logic                evt_ack_i,
  output logic                evt_overflow_o
);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  // Raw level of a released key; the synchroniser resets here so reset never looks like a press.
  localparam logic [NUM_KEYS-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

  logic [NUM_KEYS-1:0]         sync1_q, sync2_q, s;
  logic [TW-1:0]               tick_cnt_q, tick_cnt_d;
  logic                        tick;
  logic [NUM_KEYS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NUM_KEYS-1:0]         lvl_q, lvl_d, press_q, press_d, release_q, release_d;
  logic [NUM_KEYS-1:0]         press_pend_q, press_pend_d, rel_pend_q, rel_pend_d;
  logic [NUM_KEYS-1:0]         press_set, press_clr, rel_clr, sel_oh, rep_pulse, rep_pend;
  logic                        ovf_q, ovf_d, evt_valid_q, evt_valid_d, load_en;
  logic [5:0]                  evt_code_q, evt_code_d;
  logic                        sel_vld, sel_press, sel_rep;
  logic [3:0]                  sel_idx;

  assign s    = sync2_q ^ RAW_IDLE;
  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    cnt_d      = cnt_q;
    lvl_d      = lvl_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (s[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CNT_LAST) begin
          lvl_d[i] = ~lvl_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d   = lvl_d & ~lvl_q;
    release_d = ~lvl_d & lvl_q;
  end

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ? REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int HW   = $clog2(RMAX + 1);
  localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY_TICKS - 1);
  localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE_TICKS - 1);

  logic [NUM_KEYS-1:0][HW-1:0] hold_q, hold_d;
  logic [NUM_KEYS-1:0]         phase_q, phase_d, rep_q, rep_d, rep_pend_q, rep_pend_d;

  // phase_q=0 waits out the initial delay, phase_q=1 runs at the repeat rate.
  always_comb begin
    hold_d  = hold_q;
    phase_d = phase_q;
    rep_d   = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!lvl_q[i]) begin
        hold_d[i]  = '0;
        phase_d[i] = 1'b0;
      end else if (tick) begin
        if (hold_q[i] == (phase_q[i] ? RATE_LAST : DELAY_LAST)) begin
          rep_d[i]   = 1'b1;
          hold_d[i]  = '0;
          phase_d[i] = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
    rep_pend_d = (rep_pend_q & ~press_clr) | rep_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q     <= '0;
      phase_q    <= '0;
      rep_q      <= '0;
      rep_pend_q <= '0;
    end else begin
      hold_q     <= hold_d;
      phase_q    <= phase_d;
      rep_q      <= rep_d;
      rep_pend_q <= rep_pend_d;
    end
  end

  assign rep_pulse = rep_q;
  assign rep_pend  = rep_pend_q;
`else
  logic unused_rep_cfg;
  assign unused_rep_cfg = (REPEAT_DELAY_TICKS > 0) ^ (REPEAT_RATE_TICKS > 0);
  assign rep_pulse      = '0;
  assign rep_pend       = '0;
`endif

  // Releases are scanned first so any pending press overrides them.
  always_comb begin
    sel_vld   = 1'b0;
    sel_press = 1'b0;
    sel_rep   = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (rel_pend_q[i]) begin
        sel_vld   = 1'b1;
        sel_idx   = 4'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (press_pend_q[i]) begin
        sel_vld   = 1'b1;
        sel_press = 1'b1;
        sel_rep   = rep_pend[i];
        sel_idx   = 4'(i);
        sel_oh    = '0;
        sel_oh[i] = 1'b1;
      end
    end
  end

  always_comb begin
    load_en      = ~evt_valid_q | evt_ack_i;
    press_set    = press_q | rep_pulse;
    press_clr    = (load_en & sel_vld & sel_press)  ? sel_oh : '0;
    rel_clr      = (load_en & sel_vld & ~sel_press) ? sel_oh : '0;
    press_pend_d = (press_pend_q & ~press_clr) | press_set;
    rel_pend_d   = (rel_pend_q & ~rel_clr) | release_q;
    ovf_d        = ovf_q | (|(press_set & press_pend_q & ~press_clr))
                         | (|(release_q & rel_pend_q & ~rel_clr));
    evt_valid_d  = evt_valid_q;
    evt_code_d   = evt_code_q;
    if (load_en) begin
      evt_valid_d = sel_vld;
      if (sel_vld) evt_code_d = {sel_rep, sel_press, sel_idx};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q      <= RAW_IDLE;
      sync2_q      <= RAW_IDLE;
      tick_cnt_q   <= '0;
      cnt_q        <= '0;
      lvl_q        <= '0;
      press_q      <= '0;
      release_q    <= '0;
      press_pend_q <= '0;
      rel_pend_q   <= '0;
      ovf_q        <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_code_q   <= '0;
    end else begin
      sync1_q      <= key_raw_i;
      sync2_q      <= sync1_q;
      tick_cnt_q   <= tick_cnt_d;
      cnt_q        <= cnt_d;
      lvl_q        <= lvl_d;
      press_q      <= press_d;
      release_q    <= release_d;
      press_pend_q <= press_pend_d;
      rel_pend_q   <= rel_pend_d;
      ovf_q        <= ovf_d;
      evt_valid_q  <= evt_valid_d;
      evt_code_q   <= evt_code_d;
    end
  end

  assign key_level_o    = lvl_q;
  assign key_press_o    = press_q;
  assign key_release_o  = release_q;
  assign evt_valid_o    = evt_valid_q;
  assign evt_code_o     = evt_code_q;
  assign evt_overflow_o = ovf_q;
endmodule
